updown_counter_seg: RTL and testbench
=====================================

Name: updown_counter_seg

Overview:
Parametrised up/down counter with clock-enable prescaler, synchronous load, wrap or saturate mode, and terminal-count pulse. Drives two active-low 7-segment digits: a direction glyph ('U'/'d') and the hex value of the count's low nibble, plus a decimal point. It sits between the board button/switch synchronisers and the seven-segment display mux in the lab top level.

Parameters:
WIDTH, 4, count register width in bits (1..16).
MODULUS, 16, count range is 0..MODULUS-1; legal range 2..2^WIDTH.
PRESCALE, 1, count step occurs once every PRESCALE enabled clocks; 1 = every clock.
SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
en  in  1  count enable; gates both the prescaler and stepping.
up  in  1  direction: 1 = increment, 0 = decrement.
load  in  1  synchronous load strobe.
load_val  in  WIDTH  value to load.
count  out  WIDTH  current count, registered.
tc  out  1  one-cycle terminal-count pulse.
dir_q  out  1  registered direction.
seg_dir  out  7  direction glyph, {g,f,e,d,c,b,a}, active-low.
seg_val  out  7  hex digit of count[3:0] (zero-extended if WIDTH<4), active-low.
dp  out  1  decimal point, active-low.

Behaviour:
- Reset is synchronous, active-high; clock is clk.
- Reset values: count=0, tc=0, dir_q=1, seg_dir=7'b1000001 ('U'), seg_val=7'b1000000 ('0'), dp=1 (off), prescaler=0.
- Priority on each edge: rst > load > step.
- Prescaler: pcnt runs 0..PRESCALE-1 only while en=1. tick=1 when en=1 and pcnt==PRESCALE-1, and pcnt then returns to 0. When en=0, pcnt holds. rst and load clear pcnt. With PRESCALE=1, tick=en.
- load=1: count <= min(load_val, MODULUS-1). pcnt cleared, tc=0. load is not gated by en or tick.
- step (tick=1, no load): direction is sampled from up on this edge.
  - up=1, count<MODULUS-1: count+1.
  - up=1, count==MODULUS-1: wrap mode gives 0; saturate mode holds at MODULUS-1. tc=1 in both modes.
  - up=0, count>0: count-1.
  - up=0, count==0: wrap mode gives MODULUS-1; saturate mode holds at 0. tc=1 in both modes.
- tc is high only for the cycle following the boundary step. In saturate mode it re-pulses on every tick that keeps pushing into the boundary.
- dir_q <= up every clock, regardless of en.
- seg_dir is 7'b1000001 ('U') when dir_q=1 and 7'b0100001 ('d') when dir_q=0.
- seg_val and dp are registered and decoded from the next-count value, so they change on the same edge as count (0 cycles skew).
- seg_val uses the standard hex table 0-F, active-low. Examples: 0=1000000, 1=1111001, A=0001000, F=0001110.
- dp is 0 (lit) when count==MODULUS-1, otherwise 1.
- All arithmetic is WIDTH bits wide; no intermediate overflow is allowed at MODULUS=2^WIDTH.
- rst mid-step overrides everything.
- Simultaneous load and tick: load wins, and no tc is produced.

Decomposition:
- Shared package updown_pkg holds:
  - SEG_GLYPH_U and SEG_GLYPH_D constants;
  - the 16-entry hex-to-segment constant table SEG_HEX;
  - a seg_t 7-bit typedef.
- Sub-module tick_prescaler (parameter PRESCALE; ports clk, rst, en, clr, tick) encapsulates the clock-enable divider.
- Segment decode stays inline as a function using the package table.

Test Plan:
1. Defaults, rst=1 for 2 clocks, then en=1, up=1 for 17 clocks -> count 0,1..15,0. tc=1 only in the cycle after 15->0. dp=0 while count=15. seg_val=0001110 at count=15.
2. Defaults, count=0, up=0, one tick -> count=15, tc=1, seg_dir=0100001 from the first cycle after up falls.
3. MODULUS=10, SATURATE=1, load_val=9, load=1, then up=1 for 3 ticks -> count stays 9, tc pulses on each of the 3 ticks. load_val=12 -> count=9 (clamped).
4. PRESCALE=4, en=1, up=1 -> count increments every 4th clock. Drop en for 3 clocks mid-period -> prescaler phase is preserved, and the next increment arrives exactly 3 clocks late.
5. load=1 together with tick, load_val=5 -> count=5, tc=0, prescaler restarts, so the next step occurs PRESCALE clocks later.
6. rst asserted while count=7 with en=1 -> next edge gives count=0, tc=0, seg_val=1000000, dp=1, dir_q=1.

Source files
------------

// File: rtl/updown_pkg.sv
// Shared constants for the up/down counter: segment glyphs and the hex decode table.
// All segment patterns are {g,f,e,d,c,b,a}, active-low.
package updown_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_GLYPH_U = 7'b1000001;
  localparam seg_t SEG_GLYPH_D = 7'b0100001;

  localparam seg_t SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable divider: pulses tick on every PRESCALE-th enabled clock.
// The phase is frozen while en is low and restarts from zero on clr.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  assign tick = en && (pcnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pcnt <= '0;
    end else if (en) begin
      if (pcnt == LAST) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_counter_seg.sv
// Up/down counter with prescaled stepping, clamped load, wrap/saturate boundaries,
// terminal-count pulse and active-low 7-segment outputs for direction and value.
module updown_counter_seg
  import updown_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             dir_q,
  output logic [6:0]       seg_dir,
  output logic [6:0]       seg_val,
  output logic             dp
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic             tick;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;

  // Low nibble, zero-extended when the counter is narrower than a hex digit.
  function automatic seg_t seg_decode(input logic [WIDTH-1:0] v);
    logic [3:0] nib;
    nib = 4'(v);
    return SEG_HEX[nib];
  endfunction

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load),
    .tick(tick)
  );

  // Load beats a step; the boundary cases raise tc whether they wrap or hold.
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    if (load) begin
      count_nxt = (load_val > MAX) ? MAX : load_val;
    end else if (tick) begin
      if (up) begin
        if (count == MAX) begin
          tc_nxt    = 1'b1;
          count_nxt = (SATURATE != 0) ? MAX : '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end else begin
        if (count == '0) begin
          tc_nxt    = 1'b1;
          count_nxt = (SATURATE != 0) ? '0 : MAX;
        end else begin
          count_nxt = count - 1'b1;
        end
      end
    end
  end

  // Display digits are decoded from count_nxt so they land on the same edge as count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      tc      <= 1'b0;
      dir_q   <= 1'b1;
      seg_val <= SEG_HEX[0];
      dp      <= 1'b1;
    end else begin
      count   <= count_nxt;
      tc      <= tc_nxt;
      dir_q   <= up;
      seg_val <= seg_decode(count_nxt);
      dp      <= (count_nxt == MAX) ? 1'b0 : 1'b1;
    end
  end

  assign seg_dir = dir_q ? SEG_GLYPH_U : SEG_GLYPH_D;

endmodule

// File: tb/tb_updown_counter_seg.sv
// Bench for updown_counter_seg: three configurations share one stimulus stream and are
// compared every cycle against an arithmetic reference model, plus directed corner cases.
module tb_updown_counter_seg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] count_a, count_b, count_c;
  logic       tc_a, tc_b, tc_c;
  logic       dir_a, dir_b, dir_c;
  logic [6:0] seg_dir_a, seg_dir_b, seg_dir_c;
  logic [6:0] seg_val_a, seg_val_b, seg_val_c;
  logic       dp_a, dp_b, dp_c;

  logic [20:0] act [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  updown_counter_seg #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count_a), .tc(tc_a), .dir_q(dir_a), .seg_dir(seg_dir_a),
    .seg_val(seg_val_a), .dp(dp_a));

  updown_counter_seg #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count_b), .tc(tc_b), .dir_q(dir_b), .seg_dir(seg_dir_b),
    .seg_val(seg_val_b), .dp(dp_b));

  updown_counter_seg #(.WIDTH(4), .MODULUS(12), .PRESCALE(4), .SATURATE(0)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count_c), .tc(tc_c), .dir_q(dir_c), .seg_dir(seg_dir_c),
    .seg_val(seg_val_c), .dp(dp_c));

  assign act[0] = {count_a, tc_a, dir_a, seg_dir_a, seg_val_a, dp_a};
  assign act[1] = {count_b, tc_b, dir_b, seg_dir_b, seg_val_b, dp_b};
  assign act[2] = {count_c, tc_c, dir_c, seg_dir_c, seg_val_c, dp_c};

  // Reference model: plain integers per configuration
  int mod_p [3] = '{16, 10, 12};
  int pre_p [3] = '{1, 1, 4};
  int sat_p [3] = '{0, 1, 0};
  int m_count [3];
  int m_tc [3];
  int m_dir [3];
  int m_enabled [3];

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0] GLYPH_U = 7'b1000001;
  localparam logic [6:0] GLYPH_D = 7'b0100001;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    int         exp_count;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(logic r, logic e, logic u, logic l, logic [3:0] lv,
                                  int c, logic t);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.load = l; v.load_val = lv;
    v.exp_count = c; v.exp_tc = t;
    vecs.push_back(v);
  endfunction

  function automatic void model_update();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_count[i] = 0; m_tc[i] = 0; m_dir[i] = 1; m_enabled[i] = 0;
      end else begin
        m_dir[i] = int'(up);
        m_tc[i]  = 0;
        if (load) begin
          m_count[i]   = (int'(load_val) < mod_p[i]) ? int'(load_val) : mod_p[i] - 1;
          m_enabled[i] = 0;
        end else if (en) begin
          m_enabled[i]++;
          if (m_enabled[i] == pre_p[i]) begin
            m_enabled[i] = 0;
            if (up) begin
              if (m_count[i] == mod_p[i] - 1) begin
                m_tc[i] = 1;
                if (sat_p[i] == 0) m_count[i] = 0;
              end else begin
                m_count[i] = m_count[i] + 1;
              end
            end else begin
              if (m_count[i] == 0) begin
                m_tc[i] = 1;
                if (sat_p[i] == 0) m_count[i] = mod_p[i] - 1;
              end else begin
                m_count[i] = m_count[i] - 1;
              end
            end
          end
        end
      end
    end
  endfunction

  function automatic logic [20:0] exp_vec(int i);
    logic [3:0] c;
    c = 4'(m_count[i]);
    return {c, 1'(m_tc[i]), 1'(m_dir[i]), (m_dir[i] != 0) ? GLYPH_U : GLYPH_D,
            hex_tab[c], (m_count[i] == mod_p[i] - 1) ? 1'b0 : 1'b1};
  endfunction

  task automatic check_output(input string name, input logic [20:0] got,
                              input logic [20:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  // Drive one cycle, advance the model on the edge and compare every configuration.
  task automatic apply_stimulus(input logic r, input logic e, input logic u,
                                input logic l, input logic [3:0] lv);
    rst = r; en = e; up = u; load = l; load_val = lv;
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < 3; i++) check_output($sformatf("model_cfg%0d", i), act[i], exp_vec(i));
  endtask

  initial begin
    // Count-up wrap and down wrap on the default configuration
    add_vec(1, 0, 1, 0, 4'd0, 0, 0);
    add_vec(1, 0, 1, 0, 4'd0, 0, 0);
    for (int i = 1; i <= 15; i++) add_vec(0, 1, 1, 0, 4'd0, i, 0);
    add_vec(0, 1, 1, 0, 4'd0, 0, 1);
    add_vec(0, 0, 1, 0, 4'd0, 0, 0);
    add_vec(0, 1, 0, 0, 4'd0, 15, 1);
    add_vec(0, 1, 0, 0, 4'd0, 14, 0);
    add_vec(0, 0, 0, 1, 4'd9, 9, 0);
    add_vec(0, 1, 1, 1, 4'd5, 5, 0);

    foreach (vecs[k]) begin
      logic [3:0] c;
      c = 4'(vecs[k].exp_count);
      apply_stimulus(vecs[k].rst, vecs[k].en, vecs[k].up, vecs[k].load, vecs[k].load_val);
      check_output($sformatf("vec%0d", k), {count_a, tc_a, seg_dir_a, seg_val_a, dp_a},
                   {c, vecs[k].exp_tc, vecs[k].rst ? GLYPH_U : (vecs[k].up ? GLYPH_U : GLYPH_D),
                    hex_tab[c], (c == 4'd15) ? 1'b0 : 1'b1});
    end

    // Saturating configuration: clamp on load, tc re-pulses while pushing the boundary
    apply_stimulus(1, 0, 1, 0, 4'd0);
    apply_stimulus(0, 0, 1, 1, 4'd9);
    check_output("sat_load9", {tc_b, count_b}, {1'b0, 4'd9});
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 1, 1, 0, 4'd0);
      check_output($sformatf("sat_hold_top%0d", k), {tc_b, count_b, dp_b}, {1'b1, 4'd9, 1'b0});
    end
    apply_stimulus(0, 0, 1, 1, 4'd12);
    check_output("sat_clamp12", {tc_b, count_b}, {1'b0, 4'd9});
    apply_stimulus(0, 0, 0, 1, 4'd0);
    apply_stimulus(0, 1, 0, 0, 4'd0);
    check_output("sat_hold_bottom", {tc_b, count_b}, {1'b1, 4'd0});

    // Prescaler of 4: pausing en for 3 clocks delays the step by exactly 3 clocks
    apply_stimulus(1, 0, 1, 0, 4'd0);
    begin
      logic en_pat [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
      int   cnt_pat [11] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 2};
      for (int k = 0; k < 11; k++) begin
        apply_stimulus(0, en_pat[k], 1, 0, 4'd0);
        check_output($sformatf("pre_step%0d", k), {28'd0, count_c}, 32'(cnt_pat[k]));
      end
    end

    // Load coinciding with a prescaler tick: load wins and the prescaler restarts
    for (int k = 0; k < 3; k++) apply_stimulus(0, 1, 1, 0, 4'd0);
    apply_stimulus(0, 1, 1, 1, 4'd5);
    check_output("load_on_tick", {tc_c, count_c}, {1'b0, 4'd5});
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(0, 1, 1, 0, 4'd0);
      check_output($sformatf("after_load%0d", k), {28'd0, count_c}, (k == 3) ? 32'd6 : 32'd5);
    end

    // Reset while counting overrides load/step and forces dir_q high
    apply_stimulus(0, 1, 1, 1, 4'd7);
    check_output("preset7", {28'd0, count_a}, 32'd7);
    apply_stimulus(1, 1, 0, 0, 4'd0);
    check_output("rst_midcount", act[0],
                 {4'd0, 1'b0, 1'b1, 7'b1000001, 7'b1000000, 1'b1});

    // Randomised traffic against the model
    for (int k = 0; k < 600; k++) begin
      apply_stimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                     1'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
